// File: rtl/imem_loader_if.sv
// Byte-stream and imem write-port bundle for imem_loader.
// A byte moves on a posedge where byte_valid && byte_ready; byte_data is only meaningful then.
interface imem_loader_if #(
    parameter int ADDR_W = 5
);
    logic              start;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;

    modport master (
        output start, byte_valid, byte_data,
        input  byte_ready, imem_we, imem_waddr, imem_wdata
    );

    modport slave (
        input  start, byte_valid, byte_data,
        output byte_ready, imem_we, imem_waddr, imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into imem as big-endian words and holds the core until done.
// Optional trailing XOR checksum byte is enabled by defining CHECKSUM_EN.
module imem_loader #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    imem_loader_if.slave      bus,
    output logic              cpu_hold_o,
    output logic              done_o,
    output logic              error_o,
    output logic [ADDR_W:0]   word_count_o,
    output logic [2:0]        state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
`ifdef CHECKSUM_EN
        , S_CHK  = 3'd4
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        len_hi_q, len_hi_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic [1:0]        idx_q, idx_d;
    logic [23:0]       asm_q, asm_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [ADDR_W:0]   wc_q, wc_d;
`ifdef CHECKSUM_EN
    logic [7:0]        xor_q, xor_d;
`else
    logic              fin_q, fin_d;
`endif

    logic        ready;
    logic        xfer;
    logic [15:0] len16;

    assign ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) || (state_q == S_DATA)
`ifdef CHECKSUM_EN
                   || (state_q == S_CHK)
`endif
                   ;
    assign xfer  = bus.byte_valid && ready;
    assign len16 = {len_hi_q, bus.byte_data};

    always_comb begin
        state_d  = state_q;
        len_hi_d = len_hi_q;
        n_d      = n_q;
        idx_d    = idx_q;
        asm_d    = asm_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        hold_d   = hold_q;
        done_d   = done_q;
        error_d  = error_q;
        wc_d     = wc_q;
`ifdef CHECKSUM_EN
        xor_d    = xor_q;
`else
        fin_d    = fin_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.start) begin
                    state_d = S_LEN_HI;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    wc_d    = '0;
                    hold_d  = 1'b1;
                    idx_d   = '0;
`ifdef CHECKSUM_EN
                    xor_d   = '0;
`else
                    fin_d   = 1'b0;
`endif
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    len_hi_d = bus.byte_data;
                    state_d  = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    if (len16 == 16'd0 || len16 > 16'(DEPTH)) begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end else begin
                        n_d     = len16[ADDR_W:0];
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
`ifndef CHECKSUM_EN
                // Stay one cycle after the last word so done follows its write strobe.
                if (fin_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    hold_d  = 1'b0;
                end else
`endif
                if (xfer) begin
                    idx_d = idx_q + 2'd1;
`ifdef CHECKSUM_EN
                    xor_d = xor_q ^ bus.byte_data;
`endif
                    if (idx_q == 2'd3) begin
                        we_d    = 1'b1;
                        waddr_d = wc_q[ADDR_W-1:0];
                        wdata_d = {asm_q, bus.byte_data};
                        wc_d    = wc_q + 1'b1;
                        if ((wc_q + 1'b1) == n_q) begin
`ifdef CHECKSUM_EN
                            state_d = S_CHK;
`else
                            fin_d   = 1'b1;
`endif
                        end
                    end else begin
                        asm_d = {asm_q[15:0], bus.byte_data};
                    end
                end
            end
`ifdef CHECKSUM_EN
            S_CHK: begin
                if (xfer) begin
                    if (bus.byte_data == xor_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            len_hi_q <= '0;
            n_q      <= '0;
            idx_q    <= '0;
            asm_q    <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            hold_q   <= 1'b1;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            wc_q     <= '0;
`ifdef CHECKSUM_EN
            xor_q    <= '0;
`else
            fin_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            len_hi_q <= len_hi_d;
            n_q      <= n_d;
            idx_q    <= idx_d;
            asm_q    <= asm_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            hold_q   <= hold_d;
            done_q   <= done_d;
            error_q  <= error_d;
            wc_q     <= wc_d;
`ifdef CHECKSUM_EN
            xor_q    <= xor_d;
`else
            fin_q    <= fin_d;
`endif
        end
    end

    assign bus.byte_ready = ready;
    assign bus.imem_we    = we_q;
    assign bus.imem_waddr = waddr_q;
    assign bus.imem_wdata = wdata_q;
    assign cpu_hold_o     = hold_q;
    assign done_o         = done_q;
    assign error_o        = error_q;
    assign word_count_o   = wc_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table-driven loads, hand-written corner sequences and random frames
// checked against a frame-level reference model and a write scoreboard.
module tb_imem_loader;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [15:0] n;
        int          gap;
        bit          e_done;
        bit          e_err;
        int          e_wc;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();
    logic            cpu_hold, done, error;
    logic [ADDR_W:0] word_count;
    logic [2:0]      state_dbg;

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus),
        .cpu_hold_o   (cpu_hold),
        .done_o       (done),
        .error_o      (error),
        .word_count_o (word_count),
        .state_o      (state_dbg)
    );

    int total = 0;
    int bad   = 0;
    logic [ADDR_W+31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Write scoreboard: every strobe must match the next expected {addr, data}.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: addr %0h data %0h, none expected",
                         bus.imem_waddr, bus.imem_wdata);
            end else begin
                logic [ADDR_W+31:0] e;
                e = exp_q.pop_front();
                chk("write_addr", 32'(bus.imem_waddr), 32'(e[ADDR_W+31:32]));
                chk("write_data", bus.imem_wdata, e[31:0]);
            end
        end
    end

    // Reference outcome of a whole frame from its length and checksum validity.
    task automatic model_outcome(input logic [15:0] n, input bit bad_chk,
                                 output bit e_done, output bit e_err, output int e_wc);
        if (n == 0 || int'(n) > DEPTH) begin
            e_done = 0; e_err = 1; e_wc = 0;
        end else begin
            e_wc = int'(n);
`ifdef CHECKSUM_EN
            e_done = !bad_chk; e_err = bad_chk;
`else
            e_done = 1; e_err = 0;
`endif
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit st);
        int w;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            bus.byte_valid = 1'b0;
            bus.start      = 1'b0;
        end
        @(negedge clk);
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        bus.start      = st;
        w = 0;
        while (bus.byte_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20) begin
            total++;
            bad++;
            $display("FAIL byte_ready_timeout: ready=%0b want 1 for byte %0h", bus.byte_ready, b);
        end
    endtask

    task automatic idle_bus();
        @(negedge clk);
        bus.byte_valid = 1'b0;
        bus.start      = 1'b0;
    endtask

    task automatic pulse_start(input bit with_valid);
        @(negedge clk);
        bus.start      = 1'b1;
        bus.byte_valid = with_valid;
        bus.byte_data  = 8'h55;
        @(negedge clk);
        bus.start      = 1'b0;
        bus.byte_valid = 1'b0;
    endtask

    task automatic wait_end();
        int w = 0;
        while (!(done || error) && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (w >= 400) begin
            total++;
            bad++;
            $display("FAIL end_timeout: done=%0b error=%0b want one set", done, error);
        end
    endtask

    task automatic run_load(input logic [15:0] n, input bq_t d, input int gap, input bit bad_chk,
                            input int start_at, input bit no_start,
                            input bit e_done, input bit e_err, input int e_wc);
        logic [7:0] x = 8'h00;
        bit valid_len;
        valid_len = (n != 0) && (int'(n) <= DEPTH);
        if (valid_len)
            for (int k = 0; k < int'(n); k++)
                exp_q.push_back({ADDR_W'(k), d[4*k], d[4*k+1], d[4*k+2], d[4*k+3]});
        if (!no_start) begin
            pulse_start(1'b0);
            chk("start_hold", cpu_hold, 1);
            chk("start_done_clr", done, 0);
            chk("start_wc_clr", 32'(word_count), 0);
        end
        send_byte(n[15:8], gap, 1'b0);
        send_byte(n[7:0], gap, 1'b0);
        if (valid_len) begin
            for (int i = 0; i < 4 * int'(n); i++) begin
                send_byte(d[i], gap, i == start_at);
                x = x ^ d[i];
            end
`ifdef CHECKSUM_EN
            send_byte(bad_chk ? ~x : x, gap, 1'b0);
`endif
        end
        idle_bus();
        wait_end();
        @(negedge clk);
        chk("load_done", done, 32'(e_done));
        chk("load_error", error, 32'(e_err));
        chk("load_wc", 32'(word_count), 32'(e_wc));
        chk("load_hold", cpu_hold, 32'(!e_done));
        chk("load_ready_low", bus.byte_ready, 0);
        chk("load_writes_left", exp_q.size(), 0);
    endtask

    initial begin
        vec_t vt[7];
        bq_t  t1, d;
        bit   ed, ee;
        int   ewc;

        vt[0] = '{16'd2,     0, 1'b1, 1'b0, 2};
        vt[1] = '{16'd33,    0, 1'b0, 1'b1, 0};
        vt[2] = '{16'd0,     0, 1'b0, 1'b1, 0};
        vt[3] = '{16'd32,    0, 1'b1, 1'b0, 32};
        vt[4] = '{16'd1,     2, 1'b1, 1'b0, 1};
        vt[5] = '{16'h0100,  0, 1'b0, 1'b1, 0};
        vt[6] = '{16'd5,     3, 1'b1, 1'b0, 5};
        t1 = '{8'h01, 8'h23, 8'h00, 8'h00, 8'h10, 8'h45, 8'h00, 8'h00};

        bus.start = 1'b0; bus.byte_valid = 1'b0; bus.byte_data = 8'h00;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", bus.byte_ready, 0);
        chk("rst_we", bus.imem_we, 0);
        chk("rst_waddr", 32'(bus.imem_waddr), 0);
        chk("rst_wdata", bus.imem_wdata, 0);
        chk("rst_hold", cpu_hold, 1);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_wc", 32'(word_count), 0);
        reset_n = 1'b1;

        // Basic frame, with a byte offered in the start cycle that must not be taken.
        exp_q.push_back({5'd0, 32'h01230000});
        exp_q.push_back({5'd1, 32'h10450000});
        pulse_start(1'b1);
        chk("t1_ready_lenhi", bus.byte_ready, 1);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h02, 0, 1'b0);
        for (int i = 0; i < 8; i++) send_byte(t1[i], 0, 1'b0);
`ifdef CHECKSUM_EN
        send_byte(8'h77, 0, 1'b0);
        idle_bus();
        chk("t1_done_after_chk", done, 1);
        chk("t1_hold_after_chk", cpu_hold, 0);
`else
        idle_bus();
        chk("t1_last_we", bus.imem_we, 1);
        chk("t1_done_with_we", done, 0);
        chk("t1_hold_with_we", cpu_hold, 1);
        @(negedge clk);
        chk("t1_done_next", done, 1);
        chk("t1_hold_next", cpu_hold, 0);
`endif
        chk("t1_wc", 32'(word_count), 2);
        chk("t1_error", error, 0);
        chk("t1_writes_left", exp_q.size(), 0);

        // Same frame, source valid only every third cycle.
        run_load(16'd2, t1, 2, 1'b0, -1, 1'b0, 1'b1, 1'b0, 2);

        // Reset mid-frame after two data bytes.
        pulse_start(1'b0);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h02, 0, 1'b0);
        send_byte(8'hAB, 0, 1'b0);
        send_byte(8'hCD, 0, 1'b0);
        @(negedge clk);
        bus.byte_valid = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("midrst_ready", bus.byte_ready, 0);
        chk("midrst_we", bus.imem_we, 0);
        chk("midrst_waddr", 32'(bus.imem_waddr), 0);
        chk("midrst_wdata", bus.imem_wdata, 0);
        chk("midrst_hold", cpu_hold, 1);
        chk("midrst_done", done, 0);
        chk("midrst_error", error, 0);
        chk("midrst_wc", 32'(word_count), 0);
        run_load(16'd2, t1, 0, 1'b0, -1, 1'b0, 1'b1, 1'b0, 2);

        // Start pulsed mid-DATA is ignored; start in DONE restarts the load.
        d = {};
        for (int i = 0; i < 12; i++) d.push_back(8'($urandom_range(0, 255)));
        run_load(16'd3, d, 0, 1'b0, 5, 1'b0, 1'b1, 1'b0, 3);
        pulse_start(1'b0);
        chk("redo_done_clr", done, 0);
        chk("redo_hold", cpu_hold, 1);
        chk("redo_wc_clr", 32'(word_count), 0);
        chk("redo_ready", bus.byte_ready, 1);
        run_load(16'd3, d, 1, 1'b0, -1, 1'b1, 1'b1, 1'b0, 3);

`ifdef CHECKSUM_EN
        run_load(16'd2, t1, 0, 1'b1, -1, 1'b0, 1'b0, 1'b1, 2);
`endif

        for (int v = 0; v < 7; v++) begin
            d = {};
            for (int i = 0; i < 4 * DEPTH; i++) d.push_back(8'($urandom_range(0, 255)));
            run_load(vt[v].n, d, vt[v].gap, 1'b0, -1, 1'b0, vt[v].e_done, vt[v].e_err, vt[v].e_wc);
        end

        for (int r = 0; r < 12; r++) begin
            logic [15:0] n;
            bit bc;
            int gap;
            n   = 16'($urandom_range(0, 36));
            gap = $urandom_range(0, 2);
            bc  = 1'($urandom_range(0, 1));
            d = {};
            for (int i = 0; i < 4 * DEPTH; i++) d.push_back(8'($urandom));
            model_outcome(n, bc, ed, ee, ewc);
            run_load(n, d, gap, bc, -1, 1'b0, ed, ee, ewc);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
